// File: rtl/iodev_tx_scheduler_if.sv
// Bundle of the requester push port, CPU I/O port and iodev port seen by iodev_tx_scheduler.
// The slave modport is the scheduler's view; master is the view of whatever drives it.
interface iodev_tx_scheduler_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          push_valid;
  logic [7:0]    push_data;
  logic          push_ready;
  logic [LW-1:0] fifo_level;

  logic          cpu_en;
  logic [2:0]    cpu_write_enable;
  logic [23:0]   cpu_addr;
  logic [31:0]   cpu_data_in;
  logic [31:0]   cpu_data_out;
  logic          cpu_stall;

  logic          io_en;
  logic [2:0]    io_write_enable;
  logic [23:0]   io_addr;
  logic [31:0]   io_data_in;
  logic [31:0]   io_data_out;

  modport slave (
    input  push_valid, push_data, cpu_en, cpu_write_enable, cpu_addr, cpu_data_in, io_data_out,
    output push_ready, fifo_level, cpu_data_out, cpu_stall,
           io_en, io_write_enable, io_addr, io_data_in
  );

  modport master (
    output push_valid, push_data, cpu_en, cpu_write_enable, cpu_addr, cpu_data_in, io_data_out,
    input  push_ready, fifo_level, cpu_data_out, cpu_stall,
           io_en, io_write_enable, io_addr, io_data_in
  );
endinterface

// File: rtl/iodev_tx_scheduler.sv
// Byte FIFO drained into the UART data register by a poll/write engine that shares the
// iodev port with the CPU; the CPU wins ties unless the engine has been starved STARVE_LIMIT cycles.
module iodev_tx_scheduler #(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         STARVE_LIMIT = 8,
  parameter logic [3:0] STAT_ADDR    = 4'h3,
  parameter logic [3:0] DATA_ADDR    = 4'h2
) (
  input logic                 clk,
  input logic                 rst,
  iodev_tx_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   LVL_FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_POLL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          eng_req, eng_force, cpu_gnt, eng_gnt, push_fire, pop;

  assign bus.push_ready = (level_q != LVL_FULL);
  assign bus.fifo_level = level_q;
  assign push_fire      = bus.push_valid && bus.push_ready && !rst;

  // Engine is silenced during reset so the CPU sees a plain pass-through.
  assign eng_req       = !rst && ((state_q == ST_POLL) || (state_q == ST_WRITE));
  assign eng_force     = eng_req && (starve_q == STARVE_MAX);
  assign cpu_gnt       = bus.cpu_en && !eng_force;
  assign eng_gnt       = eng_req && !cpu_gnt;
  assign pop           = eng_gnt && (state_q == ST_WRITE);
  assign bus.cpu_stall = bus.cpu_en && eng_force;
  assign bus.cpu_data_out = cpu_gnt ? bus.io_data_out : '0;

  always_comb begin
    bus.io_en           = 1'b0;
    bus.io_write_enable = 3'b000;
    bus.io_addr         = '0;
    bus.io_data_in      = '0;
    if (cpu_gnt) begin
      bus.io_en           = 1'b1;
      bus.io_write_enable = bus.cpu_write_enable;
      bus.io_addr         = bus.cpu_addr;
      bus.io_data_in      = bus.cpu_data_in;
    end else if (eng_gnt) begin
      bus.io_en = 1'b1;
      if (state_q == ST_WRITE) begin
        bus.io_write_enable = 3'b100;
        bus.io_addr         = {20'b0, DATA_ADDR};
        bus.io_data_in      = {24'b0, mem_q[rd_ptr_q]};
      end else begin
        bus.io_addr = {20'b0, STAT_ADDR};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (level_q != '0) state_d = ST_POLL;
      ST_POLL: begin
        if (eng_gnt) begin
          if (level_q == '0)              state_d = ST_IDLE;
          else if (!bus.io_data_out[0])   state_d = ST_WRITE;
        end
      end
      ST_WRITE: if (eng_gnt) state_d = ST_POLL;
      default:  state_d = ST_IDLE;
    endcase

    starve_d = '0;
    if (eng_req && !eng_gnt)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);

    wr_ptr_d = wr_ptr_q + AW'(push_fire);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(push_fire) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= bus.push_data;
  end
endmodule

// File: tb/tb_iodev_tx_scheduler.sv
// Random and directed stimulus against a queue-based model of the byte stream plus a toy UART.
module tb_iodev_tx_scheduler;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iodev_tx_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

  iodev_tx_scheduler #(
    .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(8), .STAT_ADDR(4'h3), .DATA_ADDR(4'h2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  byte unsigned exp_q[$];
  int  wr_count = 0;
  int  busy_cnt = 0;
  bit  busy_hold = 1'b0;
  bit  wr_seen = 1'b0;
  logic busy;

  // Toy UART: status reads return busy in bit 0, anything else returns a fixed tag plus the address.
  assign busy = busy_hold || (busy_cnt != 0);
  assign bus.io_data_out = (bus.io_addr == 24'h3) ? {31'b0, busy} : {8'hC3, bus.io_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) step();
    step();
    @(negedge clk);
    check(tag, bus.fifo_level, 0);
    step();
  endtask

  always @(posedge clk) begin
    if (wr_seen)           busy_cnt <= 1 + $urandom_range(0, 2);
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Scoreboard: every engine write must carry the oldest byte still owed.
  always @(negedge clk) begin
    bit cpu_win, full, eng_wr;
    byte unsigned b;
    cpu_win = bus.cpu_en && !bus.cpu_stall;
    if (rst) begin
      check("rst_stall", bus.cpu_stall, 0);
      if (bus.cpu_en) check("rst_pass_addr", bus.io_addr, bus.cpu_addr);
      exp_q.delete();
      wr_seen = 1'b0;
    end else begin
      full = exp_q.size() >= DEPTH;
      check("level", bus.fifo_level, exp_q.size());
      check("push_ready", bus.push_ready, !full);
      if (cpu_win) begin
        check("cpu_io_en", bus.io_en, 1);
        check("cpu_io_addr", bus.io_addr, bus.cpu_addr);
        check("cpu_rdata", bus.cpu_data_out, bus.io_data_out);
      end else begin
        check("cpu_rdata_zero", bus.cpu_data_out, 0);
      end
      eng_wr  = !cpu_win && bus.io_en && (bus.io_write_enable == 3'b100) && (bus.io_addr == 24'h2);
      wr_seen = eng_wr;
      if (eng_wr) begin
        if (exp_q.size() == 0) begin
          check("spurious_wr", bus.io_en, 0);
        end else begin
          b = exp_q.pop_front();
          check("wr_data", bus.io_data_in, {24'b0, b});
          wr_count++;
        end
      end
      if (bus.push_valid && !full) exp_q.push_back(bus.push_data);
    end
  end

  initial begin
    int n0;
    logic [31:0] wdat;
    rst = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data = 8'h99;
    bus.cpu_en = 1'b1;
    bus.cpu_write_enable = 3'b000;
    bus.cpu_addr = 24'h000001;
    bus.cpu_data_in = 32'h0;
    repeat (3) step();

    rst = 1'b0;
    bus.push_valid = 1'b0;
    bus.cpu_en = 1'b0;
    @(negedge clk);
    check("reset_level", bus.fifo_level, 0);
    check("reset_ready", bus.push_ready, 1);
    check("reset_io_en", bus.io_en, 0);
    step();

    // Single byte into an empty FIFO with the UART idle.
    bus.push_data = 8'h41;
    bus.push_valid = 1'b1;
    step();
    bus.push_valid = 1'b0;
    @(negedge clk);
    check("lat_idle_io_en", bus.io_en, 0);
    check("lat_level1", bus.fifo_level, 1);
    step();
    @(negedge clk);
    check("lat_poll_en", bus.io_en, 1);
    check("lat_poll_we", bus.io_write_enable, 3'b000);
    check("lat_poll_addr", bus.io_addr, 24'h3);
    step();
    @(negedge clk);
    check("lat_wr_we", bus.io_write_enable, 3'b100);
    check("lat_wr_addr", bus.io_addr, 24'h2);
    check("lat_wr_data", bus.io_data_in, 32'h41);
    step();
    @(negedge clk);
    check("lat_level0", bus.fifo_level, 0);
    check("lat_repoll_addr", bus.io_addr, 24'h3);
    repeat (8) step();

    // Fill to capacity while the UART is busy, then offer one more byte.
    busy_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.push_data = 8'(i);
      bus.push_valid = 1'b1;
      step();
    end
    bus.push_data = 8'hEE;
    @(negedge clk);
    check("full_ready", bus.push_ready, 0);
    check("full_level", bus.fifo_level, DEPTH);
    step();
    bus.push_valid = 1'b0;
    busy_hold = 1'b0;
    n0 = wr_count;
    drain("full_drain_level");
    check("full_drain_cnt", wr_count - n0, DEPTH);
    repeat (6) step();

    // Starvation: the CPU hammers the port while the engine polls a busy UART.
    busy_hold = 1'b1;
    bus.push_data = 8'h55;
    bus.push_valid = 1'b1;
    step();
    bus.push_valid = 1'b0;
    repeat (4) step();
    bus.cpu_en = 1'b1;
    bus.cpu_addr = 24'h000001;
    bus.cpu_write_enable = 3'b000;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("starve_stall", bus.cpu_stall, (i % 9) == 8);
      if ((i % 9) == 8) check("starve_gnt_addr", bus.io_addr, 24'h3);
      step();
    end
    bus.cpu_en = 1'b0;
    busy_hold = 1'b0;
    drain("starve_drain_level");
    repeat (8) step();

    // CPU read while the engine is idle.
    wdat = $urandom;
    bus.cpu_en = 1'b1;
    bus.cpu_write_enable = 3'b000;
    bus.cpu_addr = 24'h000001;
    bus.cpu_data_in = wdat;
    @(negedge clk);
    check("cpu_rd_en", bus.io_en, 1);
    check("cpu_rd_we", bus.io_write_enable, 3'b000);
    check("cpu_rd_addr", bus.io_addr, 24'h1);
    check("cpu_rd_wdata", bus.io_data_in, wdat);
    check("cpu_rd_data", bus.cpu_data_out, 32'hC300_0001);
    check("cpu_rd_stall", bus.cpu_stall, 0);
    step();
    bus.cpu_en = 1'b0;

    // Random mix of pushes, CPU reads and UART busy periods.
    n0 = wr_count;
    for (int i = 0; i < 400; i++) begin
      bus.push_valid = ($urandom_range(0, 9) < 6);
      bus.push_data = 8'($urandom);
      bus.cpu_en = ($urandom_range(0, 3) == 0);
      bus.cpu_data_in = $urandom;
      step();
    end
    bus.push_valid = 1'b0;
    bus.cpu_en = 1'b0;
    drain("rand_drain_level");
    check("rand_enough_bytes", (wr_count - n0) >= 40, 1);
    repeat (8) step();

    // Reset while the engine sits in WRITE with five bytes queued.
    busy_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.push_data = 8'(8'hA0 + i);
      bus.push_valid = 1'b1;
      step();
    end
    bus.push_valid = 1'b0;
    repeat (3) step();
    busy_hold = 1'b0;
    @(negedge clk);
    check("rstw_poll_addr", bus.io_addr, 24'h3);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rstw_no_wr", bus.io_en, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstw_level", bus.fifo_level, 0);
    check("rstw_ready", bus.push_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rstw_quiet", bus.io_en, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
